// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle pixel buffer.
package tri_pkg;

    localparam int COORD_W = 3;
    localparam int GRID    = 8;
    localparam int CELLS   = GRID * GRID;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2
    } state_t;

    // Bitmap is laid out row-major, so the flat index is simply {y, x}.
    function automatic logic [5:0] cell_index(input coord_t x, input coord_t y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tri_pixel_buffer_if.sv
// Row scan-out channel of the pixel buffer: one 8-pixel row per valid/ready beat.
interface tri_pixel_buffer_if;

    logic                     row_valid;
    logic                     row_ready;
    logic [tri_pkg::GRID-1:0] row_data;
    logic [2:0]               row_idx;
    logic                     frame_last;

    modport master (
        output row_valid,
        output row_data,
        output row_idx,
        output frame_last,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_data,
        input  row_idx,
        input  frame_last,
        output row_ready
    );

endinterface

// File: rtl/tri_bitmap.sv
// 8x8 single-bit pixel store with point set, clear-all and one row read port.
module tri_bitmap
    import tri_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  coord_t          set_x,
    input  coord_t          set_y,
    input  logic            clear,
    input  coord_t          rd_row,
    output logic [GRID-1:0] rd_data,
    output logic            already_set
);

    logic [CELLS-1:0] bm;

    // Clear only happens in SCAN and set only outside it, so their priority never matters.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bm <= '0;
        end else if (set_en) begin
            bm[cell_index(set_x, set_y)] <= 1'b1;
        end
    end

    assign rd_data     = bm[{rd_row, 3'b000} +: GRID];
    assign already_set = bm[cell_index(set_x, set_y)];

endmodule

// File: rtl/tri_pixel_buffer.sv
// Collects one triangle's rendered points into an 8x8 bitmap and scans it out row by row.
// Optional distinct-pixel counter enabled by defining TRI_PIXEL_COUNT_EN.
module tri_pixel_buffer #(
    parameter int COORD_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy_i,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    tri_pixel_buffer_if.master rows,
    output logic               buf_busy,
    output logic               ovf,
    output logic [6:0]         pix_cnt
);

    import tri_pkg::state_t;
    import tri_pkg::IDLE;
    import tri_pkg::COLLECT;
    import tri_pkg::SCAN;
    import tri_pkg::GRID;

    state_t            state;
    state_t            state_next;
    logic              busy_d;
    logic [2:0]        row_ptr;
    logic              busy_rise;
    logic              busy_fall;
    logic              in_scan;
    logic              row_hs;
    logic              last_hs;
    logic              set_en;
    logic              already_set;
    logic [GRID-1:0]   row_bits;

    assign busy_rise = busy_i & ~busy_d;
    assign busy_fall = ~busy_i & busy_d;
    assign in_scan   = (state == SCAN);
    assign row_hs    = in_scan & rows.row_ready;
    assign last_hs   = row_hs & (row_ptr == 3'd7);
    assign set_en    = po & ~in_scan;

    tri_bitmap u_bitmap (
        .clk         (clk),
        .reset       (reset),
        .set_en      (set_en),
        .set_x       (xo),
        .set_y       (yo),
        .clear       (last_hs),
        .rd_row      (row_ptr),
        .rd_data     (row_bits),
        .already_set (already_set)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy_d  <= 1'b0;
            row_ptr <= 3'd0;
            ovf     <= 1'b0;
        end else begin
            state  <= state_next;
            busy_d <= busy_i;
            // Row pointer wraps 7 -> 0 naturally on the final handshake.
            if (row_hs) begin
                row_ptr <= row_ptr + 3'd1;
            end
            if (po && in_scan) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        rows.row_valid  = 1'b0;
        rows.row_data   = row_bits;
        rows.row_idx    = row_ptr;
        rows.frame_last = 1'b0;
        buf_busy        = 1'b0;
        case (state)
            IDLE: begin
                if (po || busy_rise) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (busy_fall) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                rows.row_valid  = 1'b1;
                rows.frame_last = (row_ptr == 3'd7);
                buf_busy        = 1'b1;
                if (last_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef TRI_PIXEL_COUNT_EN
    logic [6:0] cnt;

    // Only first hits on a pixel count, so duplicates leave the total unchanged.
    always_ff @(posedge clk) begin
        if (reset || last_hs) begin
            cnt <= 7'd0;
        end else if (set_en && !already_set) begin
            cnt <= cnt + 7'd1;
        end
    end

    assign pix_cnt = cnt;
`else
    logic unused_already_set;

    assign unused_already_set = already_set;
    assign pix_cnt            = 7'd0;
`endif

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed self-checking bench for tri_pixel_buffer.
module tb_tri_pixel_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy_i;
    logic       po;
    logic [2:0] xo;
    logic [2:0] yo;
    logic       buf_busy;
    logic       ovf;
    logic [6:0] pix_cnt;

    int checks = 0;
    int errors = 0;

    tri_pixel_buffer_if rows_if ();

    tri_pixel_buffer #(.COORD_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .busy_i   (busy_i),
        .po       (po),
        .xo       (xo),
        .yo       (yo),
        .rows     (rows_if),
        .buf_busy (buf_busy),
        .ovf      (ovf),
        .pix_cnt  (pix_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_pix(input int n);
`ifdef TRI_PIXEL_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic b, input logic p, input logic [2:0] x, input logic [2:0] y);
        busy_i = b;
        po     = p;
        xo     = x;
        yo     = y;
        tick();
    endtask

    // Walks rows 0..stop_row-1; at stall_row the ready is held low for stall cycles.
    task automatic scan_frame(input string name, input logic [63:0] exp_rows, input int stall_row,
                              input int stall, input int exp_cnt, input int stop_row);
        busy_i = 1'b0;
        po     = 1'b0;
        for (int i = 0; i < stop_row; i++) begin
            int n;
            n = (i == stall_row) ? stall : 0;
            for (int s = 0; s <= n; s++) begin
                check_output($sformatf("%s r%0d valid", name, i), 64'(rows_if.row_valid), 64'd1);
                check_output($sformatf("%s r%0d idx", name, i), 64'(rows_if.row_idx), 64'(i));
                check_output($sformatf("%s r%0d data", name, i), 64'(rows_if.row_data), 64'(exp_rows[i*8 +: 8]));
                check_output($sformatf("%s r%0d last", name, i), 64'(rows_if.frame_last), 64'(i == 7));
                check_output($sformatf("%s r%0d bbusy", name, i), 64'(buf_busy), 64'd1);
                check_output($sformatf("%s r%0d cnt", name, i), 64'(pix_cnt), 64'(exp_pix(exp_cnt)));
                rows_if.row_ready = (s == n);
                tick();
            end
        end
        if (stop_row == 8) begin
            check_output({name, " end bbusy"}, 64'(buf_busy), 64'd0);
            check_output({name, " end valid"}, 64'(rows_if.row_valid), 64'd0);
            check_output({name, " end last"}, 64'(rows_if.frame_last), 64'd0);
            check_output({name, " end cnt"}, 64'(pix_cnt), 64'd0);
        end
    endtask

    initial begin
        reset             = 1'b1;
        busy_i            = 1'b1;
        po                = 1'b1;
        xo                = 3'd3;
        yo                = 3'd3;
        rows_if.row_ready = 1'b0;
        repeat (3) tick();
        check_output("rst valid", 64'(rows_if.row_valid), 64'd0);
        check_output("rst data", 64'(rows_if.row_data), 64'd0);
        check_output("rst idx", 64'(rows_if.row_idx), 64'd0);
        check_output("rst last", 64'(rows_if.frame_last), 64'd0);
        check_output("rst bbusy", 64'(buf_busy), 64'd0);
        check_output("rst ovf", 64'(ovf), 64'd0);
        check_output("rst cnt", 64'(pix_cnt), 64'd0);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);

        // Basic frame; (3,3) driven during reset must not appear in row 3.
        for (int f = 0; f < 2; f++) begin
            apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
            apply_stimulus(1'b1, 1'b1, 3'd1, 3'd0);
            apply_stimulus(1'b1, 1'b1, 3'd1, 3'd1);
            apply_stimulus(1'b1, 1'b1, 3'd2, 3'd1);
            apply_stimulus(1'b1, 1'b1, 3'd1, 3'd2);
            apply_stimulus(1'b1, 1'b1, 3'd2, 3'd2);
            apply_stimulus(1'b1, 1'b1, 3'd3, 3'd2);
            check_output("collect bbusy", 64'(buf_busy), 64'd0);
            check_output("collect valid", 64'(rows_if.row_valid), 64'd0);
            apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
            if (f == 0) scan_frame("basic", 64'h0000_0000_000E_0602, 8, 0, 6, 8);
            else        scan_frame("bp", 64'h0000_0000_000E_0602, 2, 3, 6, 8);
        end

        // Duplicate point and a point coincident with the falling busy edge.
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b1, 1'b1, 3'd2, 3'd2);
        apply_stimulus(1'b1, 1'b1, 3'd2, 3'd2);
        apply_stimulus(1'b0, 1'b1, 3'd7, 3'd7);
        scan_frame("dup", 64'h8000_0000_0004_0000, 8, 0, 2, 8);

        // Point during SCAN is dropped and flags overflow.
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b1, 1'b1, 3'd3, 3'd0);
        rows_if.row_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
        check_output("ovf pre", 64'(ovf), 64'd0);
        apply_stimulus(1'b0, 1'b1, 3'd0, 3'd0);
        po = 1'b0;
        check_output("ovf set", 64'(ovf), 64'd1);
        check_output("ovf row0 data", 64'(rows_if.row_data), 64'h08);
        check_output("ovf row0 idx", 64'(rows_if.row_idx), 64'd0);
        scan_frame("ovf", 64'h0000_0000_0000_0008, 8, 0, 1, 8);
        check_output("ovf sticky", 64'(ovf), 64'd1);
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
        scan_frame("empty", 64'h0, 8, 0, 0, 8);
        check_output("ovf sticky2", 64'(ovf), 64'd1);

        // Reset in the middle of a scan, then a clean frame.
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b1, 1'b1, 3'd4, 3'd4);
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
        scan_frame("midrst", 64'h0000_0010_0000_0000, 8, 0, 1, 4);
        check_output("midrst at4 idx", 64'(rows_if.row_idx), 64'd4);
        check_output("midrst at4 data", 64'(rows_if.row_data), 64'h10);
        reset = 1'b1;
        tick();
        check_output("midrst valid", 64'(rows_if.row_valid), 64'd0);
        check_output("midrst bbusy", 64'(buf_busy), 64'd0);
        check_output("midrst idx", 64'(rows_if.row_idx), 64'd0);
        check_output("midrst ovf", 64'(ovf), 64'd0);
        check_output("midrst cnt", 64'(pix_cnt), 64'd0);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0);
        apply_stimulus(1'b1, 1'b1, 3'd5, 3'd5);
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0);
        scan_frame("post", 64'h0000_2000_0000_0000, 8, 0, 1, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
